serial_adder: RTL and testbench

Parametrised multi-cycle adder that sums two WIDTH-bit operands DIGIT bits per clock, LSB first, through a registered carry. It is the sequential, width-generic successor to the single-bit half-adder cell. It sits wherever area matters more than latency, for example accumulators and address offset logic. A start/busy/done handshake frames each operation.

---
 rtl/serial_adder_pkg.sv | 15 +
 rtl/serial_adder_fa_cell.sv | 21 ++
 rtl/serial_adder.sv | 131 +++++++++++++
 tb/tb_serial_adder.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types for serial_adder: FSM state encoding and counter sizing.
// No timing of its own; consumed by serial_adder at elaboration.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_adder_fa_cell.sv
// One-bit full adder from two half-adder stages; combinational, zero latency.
// No flow control; used as a ripple link inside serial_adder.
module fa_cell (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);

    logic w_s1;
    logic w_c1;
    logic w_c2;

    assign w_s1 = i_a ^ i_b;
    assign w_c1 = i_a & i_b;
    assign o_s  = w_s1 ^ i_c;
    assign w_c2 = w_s1 & i_c;
    assign o_c  = w_c1 | w_c2;

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder, LSB first; latency WIDTH/DIGIT cycles from accept to done.
// start is ignored while busy (no queueing); SERIAL_ADDER_SUB_EN adds the sub port.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = cnt_width(N);

    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_param_err
        $error("serial_adder: DIGIT must be >= 1 and divide WIDTH exactly");
    end

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [CNT_W-1:0] r_cnt;
    logic             r_cy;

    logic             w_sub;
    logic             w_load;
    logic             w_step;
    logic             w_last;
    logic [DIGIT:0]   w_c;
    logic [DIGIT-1:0] w_dsum;
    logic [WIDTH-1:0] w_res_next;

`ifdef SERIAL_ADDER_SUB_EN
    assign w_sub = sub;
`else
    assign w_sub = 1'b0;
`endif

    assign w_last = (r_cnt == CNT_W'(N - 1));
    assign busy   = (r_state == BUSY);
    assign done   = (r_state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // DONE accepts start exactly like IDLE so back-to-back ops lose no extra cycle.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_load       = 1'b1;
                    w_state_next = BUSY;
                end else begin
                    w_state_next = IDLE;
                end
            end
            BUSY: begin
                w_step = 1'b1;
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign w_c[0] = r_cy;

    for (genvar i = 0; i < DIGIT; i++) begin : g_ripple
        fa_cell u_fa (
            .i_a (r_a[i]),
            .i_b (r_b[i]),
            .i_c (w_c[i]),
            .o_s (w_dsum[i]),
            .o_c (w_c[i+1])
        );
    end

    // New digit enters at the MSB end; after N steps the LSB digit has reached bit 0.
    assign w_res_next = WIDTH'({w_dsum, r_res} >> DIGIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_res <= '0;
            r_cnt <= '0;
            r_cy  <= 1'b0;
            sum   <= '0;
            carry <= 1'b0;
        end else if (w_load) begin
            r_a   <= a;
            r_b   <= w_sub ? ~b : b;
            r_res <= '0;
            r_cnt <= '0;
            r_cy  <= w_sub;
        end else if (w_step) begin
            r_a   <= r_a >> DIGIT;
            r_b   <= r_b >> DIGIT;
            r_res <= w_res_next;
            r_cnt <= r_cnt + CNT_W'(1);
            r_cy  <= w_c[DIGIT];
            if (w_last) begin
                sum   <= w_res_next;
                carry <= w_c[DIGIT];
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: three instances (DIGIT 1, 2, 8) on shared stimulus,
// checked every cycle against an accept-time/arithmetic model plus literal results.
module tb_serial_adder;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;

    logic       busy_w  [3];
    logic       done_w  [3];
    logic [7:0] sum_w   [3];
    logic       carry_w [3];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // model state per instance
    bit         infl    [3];
    int         acc_cyc [3];
    bit         m_busy  [3];
    bit         m_done  [3];
    bit [7:0]   m_sum   [3];
    bit         m_cy    [3];
    bit [7:0]   p_sum   [3];
    bit         p_cy    [3];
    logic [8:0] m_s9;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8), .DIGIT(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub),
`endif
        .busy(busy_w[0]), .done(done_w[0]), .sum(sum_w[0]), .carry(carry_w[0])
    );

    serial_adder #(.WIDTH(8), .DIGIT(2)) u_d2 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub),
`endif
        .busy(busy_w[1]), .done(done_w[1]), .sum(sum_w[1]), .carry(carry_w[1])
    );

    serial_adder #(.WIDTH(8), .DIGIT(8)) u_d8 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub),
`endif
        .busy(busy_w[2]), .done(done_w[2]), .sum(sum_w[2]), .carry(carry_w[2])
    );

    function automatic int nk(input int k);
        case (k)
            0:       return 8;
            1:       return 4;
            default: return 1;
        endcase
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Model: an accepted op completes exactly N edges later with plain a+b (or a-b).
    always @(posedge clk) begin
        cyc++;
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                infl[k]   = 1'b0;
                m_busy[k] = 1'b0;
                m_done[k] = 1'b0;
                m_sum[k]  = 8'h00;
                m_cy[k]   = 1'b0;
            end else begin
                m_done[k] = 1'b0;
                if (infl[k] && cyc == acc_cyc[k] + nk(k)) begin
                    m_sum[k]  = p_sum[k];
                    m_cy[k]   = p_cy[k];
                    m_done[k] = 1'b1;
                    infl[k]   = 1'b0;
                end else if (!infl[k] && start) begin
                    infl[k]    = 1'b1;
                    acc_cyc[k] = cyc;
`ifdef SERIAL_ADDER_SUB_EN
                    if (sub) m_s9 = {1'b0, a} - {1'b0, b} + 9'h100;
                    else     m_s9 = {1'b0, a} + {1'b0, b};
`else
                    m_s9 = {1'b0, a} + {1'b0, b};
`endif
                    p_sum[k] = m_s9[7:0];
                    p_cy[k]  = m_s9[8];
                end
                m_busy[k] = infl[k];
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (!rst_n)
                chk($sformatf("reset_state_c%0d_dut%0d", cyc, k),
                    int'({busy_w[k], done_w[k], carry_w[k], sum_w[k]}), 0);
            else
                chk($sformatf("cycle_c%0d_dut%0d", cyc, k),
                    int'({busy_w[k], done_w[k], carry_w[k], sum_w[k]}),
                    int'({m_busy[k], m_done[k], m_cy[k], m_sum[k]}));
        end
    end

    // Called at a negedge; returns at the negedge where done is seen.
    task automatic wait_done(input int k, input int maxc, input logic [7:0] es,
                             input logic ec, input int eb, input string nm);
        int  nb   = 0;
        bit  seen = 1'b0;
        for (int i = 0; i < maxc && !seen; i++) begin
            if (done_w[k]) begin
                seen = 1'b1;
                chk({nm, "_sum"}, int'(sum_w[k]), int'(es));
                chk({nm, "_carry"}, int'(carry_w[k]), int'(ec));
                if (eb >= 0) chk({nm, "_busy_cycles"}, nb, eb);
            end else begin
                if (busy_w[k]) nb++;
                @(negedge clk);
            end
        end
        if (!seen) chk({nm, "_done_timeout"}, 0, 1);
    endtask

    initial begin
        int t1;
        int nd;
        rst_n = 1'b0; start = 1'b0; a = 8'h00; b = 8'h00; sub = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // FF + 01 on DIGIT=1: eight busy cycles, wraps to 00 with carry
        start = 1'b1; a = 8'hFF; b = 8'h01;
        @(negedge clk);
        start = 1'b0; a = 8'h5A; b = 8'hC3;
        wait_done(0, 20, 8'h00, 1'b1, 8, "t1_ff_plus_01");
        repeat (12) @(negedge clk);

        // DIGIT=8: single busy cycle
        start = 1'b1; a = 8'hAA; b = 8'h55;
        @(negedge clk);
        start = 1'b0; a = 8'h00; b = 8'h00;
        wait_done(2, 10, 8'hFF, 1'b0, 1, "t6_n1");
        repeat (12) @(negedge clk);

        // DIGIT=2 with a start pulse mid-operation that must be ignored
        start = 1'b1; a = 8'h3C; b = 8'h55;
        @(negedge clk);
        start = 1'b0; a = 8'h01; b = 8'h01;
        @(negedge clk);
        start = 1'b1; a = 8'hEE; b = 8'hEE;
        @(negedge clk);
        start = 1'b0;
        wait_done(1, 20, 8'h91, 1'b0, -1, "t2_digit2");
        nd = 0;
        repeat (10) begin
            @(negedge clk);
            if (done_w[1]) nd++;
        end
        chk("t2_no_extra_done", nd, 0);
        repeat (5) @(negedge clk);

        // start held high: done every N+1 cycles, then operand switch
        start = 1'b1; a = 8'h10; b = 8'h20;
        wait_done(0, 30, 8'h30, 1'b0, -1, "t3_first");
        t1 = cyc;
        @(negedge clk);
        wait_done(0, 30, 8'h30, 1'b0, -1, "t3_second");
        chk("t3_period", cyc - t1, 9);
        a = 8'h80; b = 8'h80;
        @(negedge clk);
        wait_done(0, 30, 8'h00, 1'b1, -1, "t3_switch");
        start = 1'b0;
        repeat (12) @(negedge clk);

        // reset mid-operation
        start = 1'b1; a = 8'h12; b = 8'h34;
        @(negedge clk);
        start = 1'b0;
        wait_done(0, 20, 8'h46, 1'b0, -1, "t4_pre");
        repeat (3) @(negedge clk);
        start = 1'b1; a = 8'h77; b = 8'h11;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("t4_abort_busy%0d", k), int'(busy_w[k]), 0);
            chk($sformatf("t4_abort_done%0d", k), int'(done_w[k]), 0);
            chk($sformatf("t4_abort_sum%0d", k), int'(sum_w[k]), 0);
            chk($sformatf("t4_abort_carry%0d", k), int'(carry_w[k]), 0);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        repeat (15) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) if (done_w[k]) nd++;
        end
        chk("t4_no_done_after_abort", nd, 0);
        start = 1'b1; a = 8'h01; b = 8'h02;
        @(negedge clk);
        start = 1'b0;
        wait_done(0, 20, 8'h03, 1'b0, 8, "t4_fresh");
        repeat (12) @(negedge clk);

`ifdef SERIAL_ADDER_SUB_EN
        sub = 1'b1; start = 1'b1; a = 8'h05; b = 8'h07;
        @(negedge clk);
        start = 1'b0; sub = 1'b0;
        wait_done(0, 20, 8'hFE, 1'b0, -1, "t5_5_minus_7");
        repeat (12) @(negedge clk);
        sub = 1'b1; start = 1'b1; a = 8'h07; b = 8'h05;
        @(negedge clk);
        start = 1'b0; sub = 1'b0;
        wait_done(0, 20, 8'h02, 1'b1, -1, "t5_7_minus_5");
        repeat (12) @(negedge clk);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
